// File: rtl/fetch_queue.sv
// Instruction-fetch unit: owns the fetch PC, resolves control-transfer targets,
// issues one word request at a time and buffers {pc, instr} pairs in a FIFO for decode.
module fetch_queue #(
  parameter int              W_PC     = 32,
  parameter int              W_JADDR  = 26,
  parameter int              W_IMM    = 16,
  parameter int              W_INSTR  = 32,
  parameter int              DEPTH    = 4,
  parameter logic [W_PC-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               redir_valid,
  input  logic [1:0]         redir_src,
  input  logic [W_PC-1:0]    redir_base,
  input  logic               branch_taken,
  input  logic [W_JADDR-1:0] jump_addr,
  input  logic [W_IMM-1:0]   imm,
  input  logic [W_PC-1:0]    reg_addr,
  output logic               imem_req,
  output logic [W_PC-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [W_INSTR-1:0] imem_rdata,
  output logic               out_valid,
  output logic [W_PC-1:0]    out_pc,
  output logic [W_INSTR-1:0] out_instr,
  input  logic               out_ready
);

  localparam int W_PTR = $clog2(DEPTH);
  localparam int W_CNT = W_PTR + 1;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_JUMP = 2'd1,
    SRC_BRCH = 2'd2,
    SRC_REGF = 2'd3
  } redir_src_e;

  redir_src_e         src;
  logic [W_PC-1:0]    fetch_pc;
  logic [W_PC-1:0]    req_pc;
  logic               outstanding;
  logic               discard;
  logic [W_CNT-1:0]   count;
  logic [W_PTR-1:0]   rd_ptr;
  logic [W_PTR-1:0]   wr_ptr;
  logic [W_PC-1:0]    pc_mem    [DEPTH];
  logic [W_INSTR-1:0] instr_mem [DEPTH];

  logic               redir_eff;
  logic               resp;
  logic               issue;
  logic               push;
  logic               pop;
  logic [W_PC-1:0]    seq_pc;
  logic [W_PC-1:0]    imm_ext;
  logic [W_PC-1:0]    redir_target;

  assign src       = redir_src_e'(redir_src);
  assign redir_eff = redir_valid &&
                     (src == SRC_JUMP || src == SRC_REGF ||
                      (src == SRC_BRCH && branch_taken));

  assign seq_pc  = redir_base + W_PC'(4);
  assign imm_ext = {{(W_PC-W_IMM){imm[W_IMM-1]}}, imm};

  always_comb begin
    redir_target = seq_pc;
    case (src)
      SRC_JUMP: redir_target = {seq_pc[W_PC-1:W_JADDR+2], jump_addr, 2'b00};
      SRC_BRCH: redir_target = seq_pc + (imm_ext << 2);
      SRC_REGF: redir_target = reg_addr & ~W_PC'(3);
      default:  redir_target = seq_pc;
    endcase
  end

  // Issuing only when a slot is free guarantees the eventual push has room.
  assign imem_req  = rst_n && !outstanding && (count < W_CNT'(DEPTH)) && !redir_eff;
  assign imem_addr = fetch_pc;
  assign issue     = imem_req && imem_gnt;
  assign resp      = imem_rvalid && outstanding;
  assign push      = resp && !discard && !redir_eff;
  assign pop       = out_valid && out_ready && !redir_eff;

  assign out_valid = (count != '0);
  assign out_pc    = out_valid ? pc_mem[rd_ptr]    : '0;
  assign out_instr = out_valid ? instr_mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      req_pc      <= '0;
      outstanding <= 1'b0;
      discard     <= 1'b0;
    end else if (redir_eff) begin
      fetch_pc <= redir_target;
      if (resp) begin
        outstanding <= 1'b0;
        discard     <= 1'b0;
      end else begin
        discard <= outstanding;
      end
    end else begin
      if (resp) begin
        outstanding <= 1'b0;
        discard     <= 1'b0;
      end
      if (issue) begin
        outstanding <= 1'b1;
        req_pc      <= fetch_pc;
        fetch_pc    <= fetch_pc + W_PC'(4);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (redir_eff) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= req_pc;
      instr_mem[wr_ptr] <= imem_rdata;
    end
  end

endmodule
